// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit framer.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and emits a one-cycle tick on wrap.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// RS232 transmit framer, LSB-first; parity bit from an external odd-parity detector.
// Define UART_TX_PARITY_EN for 8O1 framing, otherwise 8N1.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] tx_data_q,
    input  logic       parity_in,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] tx_data_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       serial_q, serial_d;
    logic       bit_tick;
`ifdef UART_TX_PARITY_EN
    logic       parity_q, parity_d;
`else
    logic       unused_parity_in;
    assign unused_parity_in = parity_in;
`endif

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clr  (state_q == IDLE),
        .tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    tx_data_d  = tx_data;
                    shift_d    = tx_data;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_in;
`endif
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = STOP;
            end
            STOP: begin
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) state_d = IDLE;
                    else stop_idx_d = stop_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so tx_serial is glitch-free.
        case (state_d)
            START:   serial_d = START_LEVEL;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_d;
`endif
            STOP:    serial_d = STOP_LEVEL;
            default: serial_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            serial_q   <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            serial_q   <= serial_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer (CLKS_PER_BIT=4), with a second STOP_BITS=2 instance.
module tb_uart_tx_framer;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_serial, tx_busy;
    logic [7:0] tx_data_q;
    logic       parity_in = 1'b0;

    logic [7:0] tx_data2 = '0;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2, tx_serial2, tx_busy2;
    logic [7:0] tx_data_q2;
    logic       parity_in2 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data_q(tx_data_q), .parity_in(parity_in), .tx_serial(tx_serial), .tx_busy(tx_busy)
    );

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data_q(tx_data_q2), .parity_in(parity_in2), .tx_serial(tx_serial2), .tx_busy(tx_busy2)
    );

    always #5 clk = ~clk;

    // Stand-in for parityDetector: registered odd parity, one cycle latency.
    always @(posedge clk) begin
        parity_in  <= ~^tx_data_q;
        parity_in2 <= ~^tx_data_q2;
    end

    // Busy / idle run-length monitor for the main instance.
    int   busy_run = 0, idle_run = 0, last_busy_len = 0, last_idle_len = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (tx_busy === 1'b1) begin
            if (!busy_prev) begin
                last_idle_len = idle_run;
                idle_run = 0;
            end
            busy_run++;
        end else begin
            if (busy_prev) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            idle_run++;
        end
        busy_prev = (tx_busy === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) begin
            tx_data  = b;
            tx_valid = 1'b1;
            exp_q.push_back({~^b, b});
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
    endtask

    task automatic recv_frame(output logic [7:0] d, output logic p, output logic stp,
                              output logic start_ok, output bit to);
        d = 'x; p = 1'bx; stp = 1'bx; start_ok = 1'b0; to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        if (!to) begin
            repeat (2) @(negedge clk);
            start_ok = (tx_serial === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = tx_serial;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CPB) @(negedge clk);
            p = tx_serial;
`endif
            repeat (CPB) @(negedge clk);
            stp = tx_serial;
        end
    endtask

    task automatic wait_ready(output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_serial !== 1'b1) $display("FAIL reset_serial got=%b exp=1", tx_serial); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", tx_ready); else n_pass++;
        n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", tx_busy); else n_pass++;
        n_checks++; if (tx_data_q !== 8'h00) $display("FAIL reset_data_q got=%h exp=00", tx_data_q); else n_pass++;
        n_checks++; if (tx_serial2 !== 1'b1 || tx_ready2 !== 1'b1) $display("FAIL reset_dut2 got=%b%b exp=11", tx_serial2, tx_ready2); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] d; logic p, stp, st; bit to, to2; logic [8:0] e;
        send_byte(8'h55, to);
        recv_frame(d, p, stp, st, to2);
        n_checks++; if (to || to2) $display("FAIL single_timeout got=%b%b exp=00", to, to2); else n_pass++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        n_checks++; if (st !== 1'b1) $display("FAIL single_start got=%b exp=1", st); else n_pass++;
        n_checks++; if (d !== e[7:0]) $display("FAIL single_data got=%h exp=%h", d, e[7:0]); else n_pass++;
`ifdef UART_TX_PARITY_EN
        n_checks++; if (p !== e[8]) $display("FAIL single_parity got=%b exp=%b", p, e[8]); else n_pass++;
`endif
        n_checks++; if (stp !== 1'b1) $display("FAIL single_stop got=%b exp=1", stp); else n_pass++;
        n_checks++; if (tx_data_q !== 8'h55) $display("FAIL single_data_q got=%h exp=55", tx_data_q); else n_pass++;
        wait_ready(to);
        n_checks++; if (to) $display("FAIL single_ready_timeout got=timeout exp=ready"); else n_pass++;
        n_checks++; if (last_busy_len != FRAME_BITS * CPB) $display("FAIL single_busy_len got=%0d exp=%0d", last_busy_len, FRAME_BITS * CPB); else n_pass++;
        n_checks++; if (tx_serial !== 1'b1) $display("FAIL single_idle_line got=%b exp=1", tx_serial); else n_pass++;
    endtask

    task automatic test_parity_sweep;
        logic [7:0] bytes[5] = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'hC3};
        logic [7:0] d; logic p, stp, st; bit to, to2; logic [8:0] e;
        for (int k = 0; k < 5; k++) begin
            send_byte(bytes[k], to);
            recv_frame(d, p, stp, st, to2);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
            n_checks++; if (to || to2 || d !== e[7:0]) $display("FAIL sweep_data[%0d] got=%h exp=%h", k, d, e[7:0]); else n_pass++;
`ifdef UART_TX_PARITY_EN
            n_checks++; if (p !== e[8]) $display("FAIL sweep_parity[%0d] got=%b exp=%b", k, p, e[8]); else n_pass++;
`endif
            n_checks++; if (stp !== 1'b1) $display("FAIL sweep_stop[%0d] got=%b exp=1", k, stp); else n_pass++;
            wait_ready(to);
            n_checks++; if (last_busy_len != FRAME_BITS * CPB) $display("FAIL sweep_busy_len[%0d] got=%0d exp=%0d", k, last_busy_len, FRAME_BITS * CPB); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d[2]; logic p[2], stp[2], st[2]; bit to[2]; bit released, wto;
        logic [8:0] e;
        released = 1'b0;
        wait_ready(wto);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        exp_q.push_back({~^8'hA5, 8'hA5});
        @(posedge clk);
        #1 tx_data = 8'h3C;
        exp_q.push_back({~^8'h3C, 8'h3C});
        fork
            begin
                recv_frame(d[0], p[0], stp[0], st[0], to[0]);
                recv_frame(d[1], p[1], stp[1], st[1], to[1]);
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (tx_ready === 1'b1) begin
                        @(posedge clk);
                        #1 tx_valid = 1'b0;
                        released = 1'b1;
                        break;
                    end
                end
                tx_valid = 1'b0;
            end
        join
        n_checks++; if (!released || wto) $display("FAIL b2b_second_accept got=none exp=accepted"); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
            n_checks++; if (to[k] || d[k] !== e[7:0]) $display("FAIL b2b_data[%0d] got=%h exp=%h", k, d[k], e[7:0]); else n_pass++;
`ifdef UART_TX_PARITY_EN
            n_checks++; if (p[k] !== e[8]) $display("FAIL b2b_parity[%0d] got=%b exp=%b", k, p[k], e[8]); else n_pass++;
`endif
            n_checks++; if (stp[k] !== 1'b1 || st[k] !== 1'b1) $display("FAIL b2b_framing[%0d] got=%b%b exp=11", k, st[k], stp[k]); else n_pass++;
        end
        n_checks++; if (last_idle_len != 1) $display("FAIL b2b_gap got=%0d exp=1", last_idle_len); else n_pass++;
        wait_ready(wto);
    endtask

    task automatic test_ignore_busy;
        logic [7:0] d; logic p, stp, st; bit to, to2; logic [8:0] e; logic [7:0] mid_q;
        int busy_seen;
        send_byte(8'h6D, to);
        fork
            recv_frame(d, p, stp, st, to2);
            begin
                repeat (4 * CPB) @(negedge clk);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                mid_q = tx_data_q;
            end
        join
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        n_checks++; if (to || to2 || d !== e[7:0]) $display("FAIL ignore_data got=%h exp=%h", d, e[7:0]); else n_pass++;
        n_checks++; if (mid_q !== 8'h6D) $display("FAIL ignore_data_q_mid got=%h exp=6d", mid_q); else n_pass++;
        wait_ready(to);
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_busy !== 1'b0 || tx_serial !== 1'b1) busy_seen++;
        end
        n_checks++; if (busy_seen != 0) $display("FAIL ignore_no_frame got=%0d exp=0", busy_seen); else n_pass++;
        n_checks++; if (tx_data_q !== 8'h6D) $display("FAIL ignore_data_q got=%h exp=6d", tx_data_q); else n_pass++;
    endtask

    task automatic test_reset_abort;
        logic [7:0] d; logic p, stp, st; bit to, to2; logic [8:0] e;
        send_byte(8'hF0, to);
        repeat (17) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n_checks++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
            $display("FAIL abort_state got=serial%b busy%b ready%b exp=serial1 busy0 ready1", tx_serial, tx_busy, tx_ready);
        else n_pass++;
        n_checks++; if (tx_data_q !== 8'h00) $display("FAIL abort_data_q got=%h exp=00", tx_data_q); else n_pass++;
        send_byte(8'h81, to);
        recv_frame(d, p, stp, st, to2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
        n_checks++; if (to || to2 || d !== e[7:0]) $display("FAIL abort_resend_data got=%h exp=%h", d, e[7:0]); else n_pass++;
`ifdef UART_TX_PARITY_EN
        n_checks++; if (p !== e[8]) $display("FAIL abort_resend_parity got=%b exp=%b", p, e[8]); else n_pass++;
`endif
        n_checks++; if (stp !== 1'b1 || st !== 1'b1) $display("FAIL abort_resend_framing got=%b%b exp=11", st, stp); else n_pass++;
        wait_ready(to);
        n_checks++; if (last_busy_len != FRAME_BITS * CPB) $display("FAIL abort_resend_len got=%0d exp=%0d", last_busy_len, FRAME_BITS * CPB); else n_pass++;
    endtask

    task automatic test_stop2;
        logic line[0:127];
        logic [7:0] d;
        int n;
        bit to;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready2 === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        tx_data2  = 8'hC3;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1 tx_valid2 = 1'b0;
        n = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx_busy2 !== 1'b1) break;
            line[n] = tx_serial2;
            n++;
        end
        n_checks++; if (to || n != (FRAME_BITS + 1) * CPB) $display("FAIL stop2_len got=%0d exp=%0d", n, (FRAME_BITS + 1) * CPB); else n_pass++;
        for (int i = 0; i < 8; i++) d[i] = line[(1 + i) * CPB + 2];
        n_checks++; if (line[2] !== 1'b0 || d !== 8'hC3) $display("FAIL stop2_data got=%h exp=c3", d); else n_pass++;
`ifdef UART_TX_PARITY_EN
        n_checks++; if (line[9 * CPB + 2] !== ~^8'hC3) $display("FAIL stop2_parity got=%b exp=%b", line[9 * CPB + 2], ~^8'hC3); else n_pass++;
`endif
        n_checks++; if (line[(FRAME_BITS - 1) * CPB + 2] !== 1'b1 || line[FRAME_BITS * CPB + 2] !== 1'b1)
            $display("FAIL stop2_stops got=%b%b exp=11", line[(FRAME_BITS - 1) * CPB + 2], line[FRAME_BITS * CPB + 2]);
        else n_pass++;
        n_checks++; if (tx_ready2 !== 1'b1 || tx_serial2 !== 1'b1) $display("FAIL stop2_idle got=%b%b exp=11", tx_ready2, tx_serial2); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_sweep();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_stop2();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
